// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory handshake, downstream redirect/stall inputs and fetched-word outputs.
// Optional perf-counter signals are present when IFU_PERF_CNT_EN is defined.
interface instruction_fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemData;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchOffset;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic [31:0] Instruction;
    logic [5:0]  Opcode;
    logic [31:0] PCPlus4;
    logic        InstrValid;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;

    modport master (
        output ImemReq, ImemAddr, Instruction, Opcode, PCPlus4, InstrValid, FetchCount, StallCount,
        input  ImemReady, ImemData, Stall, BranchTaken, BranchOffset, Jump, JumpIndex
    );
    modport slave (
        input  ImemReq, ImemAddr, Instruction, Opcode, PCPlus4, InstrValid, FetchCount, StallCount,
        output ImemReady, ImemData, Stall, BranchTaken, BranchOffset, Jump, JumpIndex
    );
`else
    modport master (
        output ImemReq, ImemAddr, Instruction, Opcode, PCPlus4, InstrValid,
        input  ImemReady, ImemData, Stall, BranchTaken, BranchOffset, Jump, JumpIndex
    );
    modport slave (
        input  ImemReq, ImemAddr, Instruction, Opcode, PCPlus4, InstrValid,
        output ImemReady, ImemData, Stall, BranchTaken, BranchOffset, Jump, JumpIndex
    );
`endif
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues abortable instruction-memory requests and holds one fetched word.
// Define IFU_PERF_CNT_EN to add FetchCount/StallCount performance counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'hD800_0000
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    instruction_fetch_unit_if.master bus
);
    localparam logic [0:0] ST_BOOT  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    logic        accept;
    logic        redirect;
    logic        imem_req;
    logic        fetch_hit;
    logic [31:0] target;

    assign accept    = valid_q & ~bus.Stall;
    assign redirect  = accept & (bus.Jump | bus.BranchTaken);
    assign imem_req  = (state_q == ST_FETCH) & (~valid_q | ~bus.Stall) & ~redirect;
    assign fetch_hit = imem_req & bus.ImemReady;

    // Jump wins over a simultaneous branch; both are relative to the held instruction.
    assign target = bus.Jump ? {pcplus4_q[31:28], bus.JumpIndex, 2'b00}
                             : pcplus4_q + (bus.BranchOffset << 2);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (state_q == ST_BOOT) begin
            state_d = ST_FETCH;
        end
        if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end else if (fetch_hit) begin
            instr_d   = bus.ImemData;
            pcplus4_d = pc_q + 32'd4;
            valid_d   = 1'b1;
            pc_d      = pc_q + 32'd4;
        end else if (accept) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_WORD;
            pcplus4_q <= RESET_PC;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.ImemReq     = imem_req;
    assign bus.ImemAddr    = pc_q;
    assign bus.Instruction = instr_q;
    assign bus.Opcode      = instr_q[31:26];
    assign bus.PCPlus4     = pcplus4_q;
    assign bus.InstrValid  = valid_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // A fetch is never discarded here: a redirect already suppresses the request.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_hit};
        stall_cnt_d = stall_cnt_q + {31'd0, valid_q & bus.Stall};
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.FetchCount = fetch_cnt_q;
    assign bus.StallCount = stall_cnt_q;
`endif
endmodule
